// File: rtl/reg_dump_if.sv
// Beat stream carrying one (address, data) pair per valid/ready handshake
// from the register dump engine to its consumer.
interface reg_dump_if;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_addr;
    logic [31:0] out_data;
    logic        out_last;

    modport master (
        output out_valid,
        output out_addr,
        output out_data,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_addr,
        input  out_data,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/reg_dump.sv
// Register-file dump engine: walks FIRST_REG..LAST_REG through a combinational
// read port, snapshots each value and streams it out as an (address, data) beat.
module reg_dump #(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic [4:0]  rd_reg,
    input  logic [31:0] rd_data,
    reg_dump_if.master  stream
);
    localparam logic [4:0] FIRST_ADDR = 5'(FIRST_REG);
    localparam logic [4:0] LAST_ADDR  = 5'(LAST_REG);

    typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic        valid_reg, valid_next;
    logic [4:0]  addr_reg, addr_next;
    logic [31:0] data_reg, data_next;
    logic        last_reg, last_next;

    // State and beat registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            valid_reg <= 1'b0;
            addr_reg  <= 5'd0;
            data_reg  <= 32'd0;
            last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
            addr_reg  <= addr_next;
            data_reg  <= data_next;
            last_reg  <= last_next;
        end
    end

    // Next-state logic; abort overrides every other transition, including a
    // same-cycle handshake, so an aborted beat is never considered delivered.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;
        addr_next  = addr_reg;
        data_next  = data_reg;
        last_next  = last_reg;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    cnt_next   = FIRST_ADDR;
                    state_next = READ;
                end
            end
            READ: begin
                // Snapshot the register as it reads at this edge.
                data_next  = rd_data;
                addr_next  = cnt_reg;
                last_next  = (cnt_reg == LAST_ADDR);
                valid_next = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                if (stream.out_ready) begin
                    valid_next = 1'b0;
                    if (last_reg) begin
                        state_next = DONE;
                    end else begin
                        cnt_next   = cnt_reg + 5'd1;
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (abort) begin
            state_next = IDLE;
            valid_next = 1'b0;
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = (state_reg == DONE);
    // Read address is parked at 0 whenever no register is being walked.
    assign rd_reg = (state_reg == READ || state_reg == SEND) ? cnt_reg : 5'd0;

    assign stream.out_valid = valid_reg;
    assign stream.out_addr  = addr_reg;
    assign stream.out_data  = data_reg;
    assign stream.out_last  = last_reg;
endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: stimulus pushes expected beats, a negedge
// monitor pops and compares every accepted beat.
`timescale 1ns/1ps
module tb_reg_dump;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        start0, abort0, start3, abort3;
    logic        busy0, done0, busy3, done3;
    logic [4:0]  rd_reg0, rd_reg3;
    logic [31:0] rd_data0, rd_data3;
    logic [31:0] regs [32];

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t q0[$];
    beat_t q3[$];
    beat_t got0, want0, got3, want3;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt0 = 0;
    int done_cnt3 = 0;
    int last_hs_cyc = 0;

    reg_dump_if bus0();
    reg_dump_if bus3();

    // Register-file model: combinational read, register 0 hard-wired to 0.
    assign rd_data0 = (rd_reg0 == 5'd0) ? 32'd0 : regs[rd_reg0];
    assign rd_data3 = (rd_reg3 == 5'd0) ? 32'd0 : regs[rd_reg3];

    reg_dump dut0 (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start0),
        .abort   (abort0),
        .busy    (busy0),
        .done    (done0),
        .rd_reg  (rd_reg0),
        .rd_data (rd_data0),
        .stream  (bus0)
    );

    reg_dump #(.FIRST_REG(3), .LAST_REG(3)) dut3 (
        .clk     (clk),
        .rstn    (rstn),
        .start   (start3),
        .abort   (abort3),
        .busy    (busy3),
        .done    (done3),
        .rd_reg  (rd_reg3),
        .rd_data (rd_data3),
        .stream  (bus3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t mk(input int a, input logic [31:0] d, input logic l);
        beat_t b;
        b.addr = 5'(a);
        b.data = d;
        b.last = l;
        return b;
    endfunction

    function automatic logic [31:0] model_rd(input int i);
        return (i == 0) ? 32'd0 : regs[i];
    endfunction

    // Monitor: a handshake seen before the edge (and not aborted) is a delivery.
    always @(negedge clk) begin
        if (done0) done_cnt0++;
        if (done3) done_cnt3++;
        if (rstn && bus0.out_valid && bus0.out_ready && !abort0) begin
            got0 = {bus0.out_addr, bus0.out_data, bus0.out_last};
            $display("beat dut0 addr=%0d data=%08h last=%0b", got0.addr, got0.data, got0.last);
            chk("beat0_pending", 64'(q0.size() > 0), 1);
            if (q0.size() > 0) begin
                want0 = q0.pop_front();
                chk("beat0", got0, want0);
            end
            if (got0.last) last_hs_cyc = cyc + 1;
        end
        if (rstn && bus3.out_valid && bus3.out_ready && !abort3) begin
            got3 = {bus3.out_addr, bus3.out_data, bus3.out_last};
            $display("beat dut3 addr=%0d data=%08h last=%0b", got3.addr, got3.data, got3.last);
            chk("beat3_pending", 64'(q3.size() > 0), 1);
            if (q3.size() > 0) begin
                want3 = q3.pop_front();
                chk("beat3", got3, want3);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int start_cyc, fell_cyc, dc;
        logic [31:0] d;
        logic hit, bp, w5, w20, any_busy;

        rstn = 1'b0;
        start0 = 1'b0; abort0 = 1'b0; start3 = 1'b0; abort3 = 1'b0;
        bus0.out_ready = 1'b0;
        bus3.out_ready = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'h1000_0000 + 32'(i);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_rd_reg", rd_reg0, 0);
        chk("rst_valid", bus0.out_valid, 0);
        chk("rst_addr", bus0.out_addr, 0);
        chk("rst_data", bus0.out_data, 0);
        chk("rst_last", bus0.out_last, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();

        // Full dump with out_ready tied high
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 32; i++)
            q0.push_back(mk(i, (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i), i == 31));
        dc = done_cnt0;
        start_cyc = cyc;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        fell_cyc = 0;
        for (int t = 0; t < 200; t++) begin
            if (!busy0) begin fell_cyc = cyc; break; end
            tick();
        end
        chk("dump1_idle", busy0, 0);
        chk("dump1_latency", 64'(last_hs_cyc - (start_cyc + 1)), 64);
        chk("dump1_busy_fall", 64'(fell_cyc - start_cyc), 66);
        chk("dump1_done_pulses", 64'(done_cnt0 - dc), 1);
        chk("dump1_drained", 64'(q0.size()), 0);

        // Backpressure at addr 7 plus snapshot writes to r20 and r5
        regs[7] = 32'hDEAD_BEEF;
        for (int i = 0; i < 32; i++) begin
            d = (i == 0) ? 32'd0 : 32'h1000_0000 + 32'(i);
            if (i == 7)  d = 32'hDEAD_BEEF;
            if (i == 20) d = 32'hAAAA_5555;
            q0.push_back(mk(i, d, i == 31));
        end
        dc = done_cnt0;
        bp = 1'b0; w5 = 1'b0; w20 = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int t = 0; t < 300; t++) begin
            if (!busy0) break;
            if (bus0.out_valid && bus0.out_addr == 5'd5 && !w5) begin
                regs[5] = 32'h0000_1234;
                w5 = 1'b1;
            end
            if (bus0.out_valid && bus0.out_addr == 5'd10 && !w20) begin
                regs[20] = 32'hAAAA_5555;
                w20 = 1'b1;
            end
            if (bus0.out_valid && bus0.out_addr == 5'd7 && !bp) begin
                bp = 1'b1;
                bus0.out_ready = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    chk("bp_hold", {bus0.out_valid, bus0.out_addr, bus0.out_data},
                        {1'b1, 5'd7, 32'hDEAD_BEEF});
                    tick();
                end
                bus0.out_ready = 1'b1;
            end
            tick();
        end
        chk("dump2_idle", busy0, 0);
        chk("dump2_bp_seen", bp, 1);
        chk("dump2_done_pulses", 64'(done_cnt0 - dc), 1);
        chk("dump2_drained", 64'(q0.size()), 0);

        // Abort together with out_ready while beat 12 is offered
        for (int i = 0; i < 12; i++) q0.push_back(mk(i, model_rd(i), 1'b0));
        dc = done_cnt0;
        hit = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int t = 0; t < 100; t++) begin
            if (bus0.out_valid && bus0.out_addr == 5'd12) begin
                abort0 = 1'b1;
                tick();
                abort0 = 1'b0;
                hit = 1'b1;
                chk("abort_valid", bus0.out_valid, 0);
                chk("abort_busy", busy0, 0);
                break;
            end
            tick();
        end
        chk("abort_reached", hit, 1);
        repeat (3) tick();
        chk("abort_no_done", 64'(done_cnt0 - dc), 0);
        chk("abort_drained", 64'(q0.size()), 0);

        // Restart dumps from address 0 again
        for (int i = 0; i < 32; i++) q0.push_back(mk(i, model_rd(i), i == 31));
        dc = done_cnt0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (!busy0) break;
            tick();
        end
        chk("dump4_idle", busy0, 0);
        chk("dump4_done_pulses", 64'(done_cnt0 - dc), 1);
        chk("dump4_drained", 64'(q0.size()), 0);

        // Single-register dump with start held high throughout
        regs[3] = 32'h0000_0033;
        q3.push_back(mk(3, 32'h0000_0033, 1'b1));
        dc = done_cnt3;
        hit = 1'b0;
        start3 = 1'b1;
        for (int t = 0; t < 50; t++) begin
            tick();
            if (t == 2) bus3.out_ready = 1'b1;
            if (done3) begin
                start3 = 1'b0;
                hit = 1'b1;
                break;
            end
        end
        chk("one_done_seen", hit, 1);
        any_busy = 1'b0;
        for (int t = 0; t < 6; t++) begin
            tick();
            any_busy = any_busy | busy3;
        end
        chk("one_no_redump", any_busy, 0);
        chk("one_done_pulses", 64'(done_cnt3 - dc), 1);
        chk("one_drained", 64'(q3.size()), 0);

        // Asynchronous reset while beat 2 is held in SEND
        for (int i = 0; i < 2; i++) q0.push_back(mk(i, model_rd(i), 1'b0));
        dc = done_cnt0;
        hit = 1'b0;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int t = 0; t < 50; t++) begin
            if (bus0.out_valid && bus0.out_addr == 5'd2) begin
                bus0.out_ready = 1'b0;
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("arst_reached", hit, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_valid", bus0.out_valid, 0);
        chk("arst_busy", busy0, 0);
        chk("arst_rd_reg", rd_reg0, 0);
        chk("arst_done", done0, 0);
        #3;
        rstn = 1'b1;
        bus0.out_ready = 1'b1;
        any_busy = 1'b0;
        for (int t = 0; t < 5; t++) begin
            tick();
            any_busy = any_busy | busy0;
        end
        chk("arst_stays_idle", any_busy, 0);
        chk("arst_no_done", 64'(done_cnt0 - dc), 0);
        chk("arst_drained", 64'(q0.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
